// File: rtl/cim_pkg.sv
// Shared types and helpers for the tiled CIM controller and its output buffer.
package cim_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        OUT   = 3'd4
    } cim_ctrl_state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/cim_obuf.sv
// Output vector buffer: writes one tile slice at a time, keeping only the
// leading columns that belong to the assembled output vector.
module cim_obuf
    import cim_pkg::*;
#(
    parameter int DATATYPE_SIZE = 8,
    parameter int XBAR_SIZE     = 256,
    parameter int OUTPUT_SIZE   = 512,
    parameter int ADDR_W        = 1,
    parameter int COLS_W        = 9
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_wr_en,
    input  logic [ADDR_W-1:0]                  i_wr_addr,
    input  logic [COLS_W-1:0]                  i_wr_cols,
    input  logic [DATATYPE_SIZE*XBAR_SIZE-1:0] i_wr_data,
    output logic [DATATYPE_SIZE*OUTPUT_SIZE-1:0] o_data
);

    logic [DATATYPE_SIZE*OUTPUT_SIZE-1:0] r_data;

    // Every output element j belongs to tile j/XBAR_SIZE, column j%XBAR_SIZE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_data <= '0;
        end else if (i_wr_en) begin
            for (int j = 0; j < OUTPUT_SIZE; j++) begin
                if ((i_wr_addr == ADDR_W'(j / XBAR_SIZE)) &&
                    (COLS_W'(j % XBAR_SIZE) < i_wr_cols)) begin
                    r_data[j*DATATYPE_SIZE +: DATATYPE_SIZE] <=
                        i_wr_data[(j % XBAR_SIZE)*DATATYPE_SIZE +: DATATYPE_SIZE];
                end
            end
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/cim_tile_ctrl.sv
// Tiled CIM controller: issues one input vector to every crossbar tile in turn
// and assembles the per-tile results into a single downstream output vector.
module cim_tile_ctrl
    import cim_pkg::*;
#(
    parameter int DATATYPE_SIZE = 8,
    parameter int INPUT_SIZE    = 5,
    parameter int XBAR_SIZE     = 256,
    parameter int OUTPUT_SIZE   = 512,
    localparam int NUM_TILES    = ceil_div(OUTPUT_SIZE, XBAR_SIZE),
    localparam int ADDR_W       = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_start,
    output logic                                 o_busy,
    input  logic [DATATYPE_SIZE*INPUT_SIZE-1:0]  i_data,
    output logic                                 o_tile_start,
    output logic [ADDR_W-1:0]                    o_tile_addr,
    output logic [DATATYPE_SIZE*INPUT_SIZE-1:0]  o_tile_data,
    input  logic                                 i_tile_done,
    input  logic [DATATYPE_SIZE*XBAR_SIZE-1:0]   i_tile_data,
    input  logic                                 i_busy,
    output logic                                 o_start,
    output logic [DATATYPE_SIZE*OUTPUT_SIZE-1:0] o_data
);

    localparam int LAST_COLS = OUTPUT_SIZE - (NUM_TILES - 1) * XBAR_SIZE;
    localparam int COLS_W    = $clog2(XBAR_SIZE + 1);

    cim_ctrl_state_t                        r_state;
    cim_ctrl_state_t                        w_next;
    logic [ADDR_W-1:0]                      r_addr;
    logic [DATATYPE_SIZE*INPUT_SIZE-1:0]    r_in;
    logic                                   w_accept;
    logic                                   w_last;
    logic                                   w_wr_en;
    logic [COLS_W-1:0]                      w_wr_cols;

    assign w_accept  = (r_state == IDLE) && i_start;
    assign w_last    = (r_addr == ADDR_W'(NUM_TILES - 1));
    assign w_wr_en   = (r_state == WAIT) && i_tile_done;
    assign w_wr_cols = w_last ? COLS_W'(LAST_COLS) : COLS_W'(XBAR_SIZE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next = ISSUE;
            ISSUE:   w_next = WAIT;
            WAIT:    if (i_tile_done) w_next = w_last ? HOLD : ISSUE;
            HOLD:    if (!i_busy) w_next = OUT;
            OUT:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        o_busy       = (r_state != IDLE);
        o_tile_start = (r_state == ISSUE);
        o_start      = (r_state == OUT);
    end

    // The tile index advances only once the current tile has reported back.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_addr <= '0;
            r_in   <= '0;
        end else if (w_accept) begin
            r_addr <= '0;
            r_in   <= i_data;
        end else if (w_wr_en && !w_last) begin
            r_addr <= r_addr + ADDR_W'(1);
        end
    end

    assign o_tile_addr = r_addr;
    assign o_tile_data = r_in;

    cim_obuf #(
        .DATATYPE_SIZE (DATATYPE_SIZE),
        .XBAR_SIZE     (XBAR_SIZE),
        .OUTPUT_SIZE   (OUTPUT_SIZE),
        .ADDR_W        (ADDR_W),
        .COLS_W        (COLS_W)
    ) u_obuf (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_addr),
        .i_wr_cols (w_wr_cols),
        .i_wr_data (i_tile_data),
        .o_data    (o_data)
    );

endmodule

// File: tb/tb_cim_tile_ctrl.sv
// Directed bench for cim_tile_ctrl: default two-tile build, a ragged 300-column
// build and a single-tile build, all driven from one linear stimulus sequence.
module tb_cim_tile_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance 0: defaults (OUTPUT_SIZE=512, two full tiles)
    logic          s0, d0, b0;
    logic [39:0]   id0;
    logic [2047:0] td0;
    logic          busy0, ts0, st0;
    logic [0:0]    ta0;
    logic [39:0]   otd0;
    logic [4095:0] od0;

    // Instance 1: OUTPUT_SIZE=300 (last tile partially used)
    logic          s1, d1, b1;
    logic [39:0]   id1;
    logic [2047:0] td1;
    logic          busy1, ts1, st1;
    logic [0:0]    ta1;
    logic [39:0]   otd1;
    logic [2399:0] od1;

    // Instance 2: OUTPUT_SIZE=256 (single tile)
    logic          s2, d2, b2;
    logic [39:0]   id2;
    logic [2047:0] td2;
    logic          busy2, ts2, st2;
    logic [0:0]    ta2;
    logic [39:0]   otd2;
    logic [2047:0] od2;

    cim_tile_ctrl u0 (
        .clk(clk), .rst(rst), .i_start(s0), .o_busy(busy0), .i_data(id0),
        .o_tile_start(ts0), .o_tile_addr(ta0), .o_tile_data(otd0),
        .i_tile_done(d0), .i_tile_data(td0), .i_busy(b0), .o_start(st0), .o_data(od0)
    );

    cim_tile_ctrl #(.OUTPUT_SIZE(300)) u1 (
        .clk(clk), .rst(rst), .i_start(s1), .o_busy(busy1), .i_data(id1),
        .o_tile_start(ts1), .o_tile_addr(ta1), .o_tile_data(otd1),
        .i_tile_done(d1), .i_tile_data(td1), .i_busy(b1), .o_start(st1), .o_data(od1)
    );

    cim_tile_ctrl #(.OUTPUT_SIZE(256)) u2 (
        .clk(clk), .rst(rst), .i_start(s2), .o_busy(busy2), .i_data(id2),
        .o_tile_start(ts2), .o_tile_addr(ta2), .o_tile_data(otd2),
        .i_tile_done(d2), .i_tile_data(td2), .i_busy(b2), .o_start(st2), .o_data(od2)
    );

    int            checks   = 0;
    int            failures = 0;
    logic [4095:0] ev;
    logic [4095:0] ob;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compares n byte elements of ob against ev, reporting the first differing one.
    task automatic chk_vec(input string tag, input int n);
        int bad;
        bad = 0;
        for (int j = 0; j < n; j++) begin
            if (ob[j*8 +: 8] !== ev[j*8 +: 8]) begin
                bad = j;
                break;
            end
        end
        chk($sformatf("%s[%0d]", tag, bad), 64'(ob[bad*8 +: 8]), 64'(ev[bad*8 +: 8]));
    endtask

    task automatic fill(input int lo, input int hi, input logic [7:0] v);
        for (int j = lo; j < hi; j++) ev[j*8 +: 8] = v;
    endtask

    initial begin
        rst = 1'b0;
        {s0, d0, b0, s1, d1, b1, s2, d2, b2} = '0;
        id0 = '0; id1 = '0; id2 = '0;
        td0 = '0; td1 = '0; td2 = '0;
        ev  = '0;
        tick();
        tick();

        // Reset state
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_tile_start", 64'(ts0), 64'd0);
        chk("rst_start", 64'(st0), 64'd0);
        ob = od0; ev = '0; chk_vec("rst_odata", 512);
        rst = 1'b1;
        tick();

        // Job 1, minimum latency: accept in cycle 0
        s0 = 1'b1; id0 = 40'h0504030201;
        tick();                                   // cycle 1: ISSUE tile 0
        s0 = 1'b0;
        chk("j1_ts_c1", 64'(ts0), 64'd1);
        chk("j1_addr0", 64'(ta0), 64'd0);
        chk("j1_tdata", 64'(otd0), 64'h0504030201);
        chk("j1_busy", 64'(busy0), 64'd1);
        tick();                                   // cycle 2: WAIT
        chk("j1_ts_c2", 64'(ts0), 64'd0);
        d0 = 1'b1; td0 = {256{8'h11}};
        tick();                                   // cycle 3: ISSUE tile 1
        d0 = 1'b0;
        chk("j1_ts_c3", 64'(ts0), 64'd1);
        chk("j1_addr1", 64'(ta0), 64'd1);
        tick();                                   // cycle 4: WAIT
        d0 = 1'b1; td0 = {256{8'h22}};
        tick();                                   // cycle 5: HOLD
        d0 = 1'b0;
        chk("j1_start_c5", 64'(st0), 64'd0);
        chk("j1_busy_c5", 64'(busy0), 64'd1);
        tick();                                   // cycle 6: OUT
        chk("j1_start_c6", 64'(st0), 64'd1);
        ev = '0; fill(0, 256, 8'h11); fill(256, 512, 8'h22);
        ob = od0; chk_vec("j1_odata", 512);
        tick();
        chk("j1_start_c7", 64'(st0), 64'd0);
        chk("j1_busy_c7", 64'(busy0), 64'd0);
        ob = od0; chk_vec("j1_odata_hold", 512);

        // Job 2: stray start in WAIT, stray done in HOLD, downstream busy
        b0 = 1'b1;
        s0 = 1'b1; id0 = 40'h0A0B0C0D0E;
        tick();                                   // ISSUE tile 0
        s0 = 1'b0;
        tick();                                   // WAIT, no done yet
        s0 = 1'b1; id0 = 40'hFFEEDDCCBB;
        tick();                                   // still WAIT
        s0 = 1'b0;
        chk("j2_tdata_kept", 64'(otd0), 64'h0A0B0C0D0E);
        chk("j2_ts_wait", 64'(ts0), 64'd0);
        d0 = 1'b1; td0 = {256{8'h33}};
        tick();                                   // ISSUE tile 1
        d0 = 1'b0;
        chk("j2_ts_t1", 64'(ts0), 64'd1);
        chk("j2_addr1", 64'(ta0), 64'd1);
        tick();                                   // WAIT
        d0 = 1'b1; td0 = {256{8'h44}};
        tick();                                   // HOLD
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("j2_hold_start%0d", i), 64'(st0), 64'd0);
            chk($sformatf("j2_hold_busy%0d", i), 64'(busy0), 64'd1);
            d0 = (i == 0); td0 = {256{8'h99}};
            tick();
        end
        d0 = 1'b0;
        b0 = 1'b0;
        chk("j2_start_pre", 64'(st0), 64'd0);
        tick();                                   // OUT
        chk("j2_start", 64'(st0), 64'd1);
        chk("j2_tdata_end", 64'(otd0), 64'h0A0B0C0D0E);
        ev = '0; fill(0, 256, 8'h33); fill(256, 512, 8'h44);
        ob = od0; chk_vec("j2_odata", 512);
        tick();

        // Job 3: reset in the middle of WAIT
        s0 = 1'b1; id0 = 40'h1122334455;
        tick();
        s0 = 1'b0;
        tick();                                   // WAIT
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("j3_busy_rst", 64'(busy0), 64'd0);
        chk("j3_tdata_rst", 64'(otd0), 64'd0);
        ob = od0; ev = '0; chk_vec("j3_odata_rst", 512);
        d0 = 1'b1; td0 = {256{8'h55}};
        tick();
        d0 = 1'b0;
        chk("j3_late_done_busy", 64'(busy0), 64'd0);
        chk("j3_late_done_start", 64'(st0), 64'd0);
        ob = od0; chk_vec("j3_late_done_odata", 512);

        // Job 4: normal job after reset
        s0 = 1'b1; id0 = 40'h0102030405;
        tick();
        s0 = 1'b0;
        chk("j4_addr0", 64'(ta0), 64'd0);
        chk("j4_ts", 64'(ts0), 64'd1);
        tick();
        d0 = 1'b1; td0 = {256{8'h66}};
        tick();
        d0 = 1'b0;
        chk("j4_addr1", 64'(ta0), 64'd1);
        tick();
        d0 = 1'b1; td0 = {256{8'h77}};
        tick();
        d0 = 1'b0;
        tick();
        chk("j4_start", 64'(st0), 64'd1);
        ev = '0; fill(0, 256, 8'h66); fill(256, 512, 8'h77);
        ob = od0; chk_vec("j4_odata", 512);

        // OUTPUT_SIZE=300: tile 1 column c carries value c, only 44 columns kept
        s1 = 1'b1; id1 = 40'h0504030201;
        tick();
        s1 = 1'b0;
        chk("r_addr0", 64'(ta1), 64'd0);
        tick();
        d1 = 1'b1; td1 = {256{8'hAB}};
        tick();
        d1 = 1'b0;
        chk("r_addr1", 64'(ta1), 64'd1);
        chk("r_ts1", 64'(ts1), 64'd1);
        tick();
        d1 = 1'b1;
        for (int c = 0; c < 256; c++) td1[c*8 +: 8] = 8'(c);
        tick();                                   // HOLD
        d1 = 1'b0;
        chk("r_hold_ts", 64'(ts1), 64'd0);
        chk("r_hold_start", 64'(st1), 64'd0);
        tick();                                   // OUT
        chk("r_start", 64'(st1), 64'd1);
        ev = '0; fill(0, 256, 8'hAB);
        for (int c = 0; c < 44; c++) ev[(256 + c)*8 +: 8] = 8'(c);
        ob = '0; ob[2399:0] = od1; chk_vec("r_odata", 300);
        chk("r_last_elem", 64'(od1[2399:2392]), 64'd43);
        tick();

        // OUTPUT_SIZE=256: single tile, o_start in cycle 4
        s2 = 1'b1; id2 = 40'h0504030201;
        tick();                                   // cycle 1
        s2 = 1'b0;
        chk("s_ts_c1", 64'(ts2), 64'd1);
        chk("s_addr", 64'(ta2), 64'd0);
        tick();                                   // cycle 2
        d2 = 1'b1; td2 = {256{8'hC3}};
        tick();                                   // cycle 3
        d2 = 1'b0;
        chk("s_ts_c3", 64'(ts2), 64'd0);
        chk("s_start_c3", 64'(st2), 64'd0);
        tick();                                   // cycle 4
        chk("s_start_c4", 64'(st2), 64'd1);
        ev = '0; fill(0, 256, 8'hC3);
        ob = '0; ob[2047:0] = od2; chk_vec("s_odata", 256);
        tick();
        chk("s_busy_end", 64'(busy2), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cim_tile_ctrl.md
Name: cim_tile_ctrl

Overview:
- Parametrised successor to the single-transfer CIM controller.
- Accepts one input vector, sequences it through every crossbar tile needed to cover OUTPUT_SIZE columns, and gathers the per-tile results into one output vector.
- Presents the vector downstream with a start/busy handshake.
- Sits between the input buffer (upstream) and the next layer or output buffer (downstream); drives the crossbar tile array directly.

Parameters:
- DATATYPE_SIZE, 8, bits per element.
- INPUT_SIZE, 5, elements per input vector.
- XBAR_SIZE, 256, columns per crossbar tile.
- OUTPUT_SIZE, 512, total output elements; need not be a multiple of XBAR_SIZE.
- NUM_TILES, derived, ceil(OUTPUT_SIZE/XBAR_SIZE).
- LAST_COLS, derived, OUTPUT_SIZE - (NUM_TILES-1)*XBAR_SIZE, valid columns in the final tile (1..XBAR_SIZE).
- ADDR_W, derived, max(1, $clog2(NUM_TILES)).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset (0 = reset), sampled on posedge clk.
- i_start  in  1  upstream: input vector valid, one-cycle pulse or level.
- o_busy  out  1  upstream: controller occupied; i_start ignored while high.
- i_data  in  DATATYPE_SIZE x INPUT_SIZE  input vector, sampled when accepted.
- o_tile_start  out  1  one-cycle pulse launching the tile at o_tile_addr.
- o_tile_addr  out  ADDR_W  tile index currently issued or awaited.
- o_tile_data  out  DATATYPE_SIZE x INPUT_SIZE  latched input vector broadcast to tiles.
- i_tile_done  in  1  tile result valid (single-cycle).
- i_tile_data  in  DATATYPE_SIZE x XBAR_SIZE  tile result columns.
- i_busy  in  1  downstream: not ready to accept.
- o_start  out  1  downstream: one-cycle pulse, o_data valid.
- o_data  out  DATATYPE_SIZE x OUTPUT_SIZE  assembled output vector.

Behaviour:
- Reset (rst==0 at posedge):
  - State returns to IDLE; tile address counter = 0.
  - Input latch and output buffer are cleared to 0.
  - o_busy, o_tile_start and o_start are 0.
  - Reset mid-operation aborts the job immediately. No o_start is issued, and i_tile_done arriving after reset is ignored.
- States: IDLE, ISSUE, WAIT, HOLD, OUT. Registered state; outputs decoded from state.
- IDLE:
  - o_busy=0.
  - On i_start=1: latch i_data into the input latch, set addr=0, go to ISSUE.
- ISSUE:
  - o_busy=1, o_tile_start=1, o_tile_addr=addr.
  - Go to WAIT unconditionally (exactly one cycle).
- WAIT:
  - o_busy=1.
  - On i_tile_done=1: write columns [0..cols-1] of i_tile_data into o_data[addr*XBAR_SIZE +: cols]. cols is XBAR_SIZE, or LAST_COLS when addr==NUM_TILES-1; excess columns are discarded.
  - If addr==NUM_TILES-1, go to HOLD; otherwise addr++ and go to ISSUE.
  - No timeout.
- HOLD:
  - o_busy=1.
  - If i_busy==0, go to OUT; otherwise stay.
  - HOLD is always visited, for at least one cycle.
- OUT:
  - o_busy=1, o_start=1 for exactly one cycle; go to IDLE.
  - o_data stays stable until the first tile write of the next job. The downstream block captures it on o_start.
- i_start while o_busy=1: ignored; no queueing.
- i_tile_done outside WAIT: ignored.
- o_tile_data holds the latched vector from acceptance until the next acceptance.
- Minimum latency, i_tile_done returned in the first WAIT cycle and i_busy=0: accept at cycle 0, then 2 cycles per tile, then HOLD, then o_start. For NUM_TILES=2, o_start is high in cycle 6.
- NUM_TILES=1 is legal: ISSUE, WAIT, HOLD, OUT.

Decomposition:
- Shared package cim_pkg holds:
  - the state enum typedef (cim_ctrl_state_t: IDLE, ISSUE, WAIT, HOLD, OUT);
  - the ceil-div function used for NUM_TILES.
- The derived LAST_COLS and ADDR_W are computed as localparams in the module.
- One sub-module: cim_obuf, the output buffer.
  - Indexed write of one tile slice with a column-valid count.
  - Synchronous active-low clear.

Test Plan:
- Defaults. Pulse i_start with i_data={1,2,3,4,5}. Return i_tile_done one cycle after each o_tile_start: tile 0 data all 0x11, tile 1 data all 0x22. Required: o_tile_addr issued as 0 then 1; o_tile_data={1,2,3,4,5}; o_start high in cycle 6; o_data[0..255]=0x11, o_data[256..511]=0x22.
- OUTPUT_SIZE=300, XBAR_SIZE=256, tile 1 data column c = c. Required: NUM_TILES=2; o_data[256..299]=0..43; columns 44..255 of tile 1 are dropped.
- Hold i_busy=1 for 10 cycles after the last tile done. Required: remains in HOLD with o_start=0 and o_busy=1; o_start pulses one cycle after i_busy falls.
- Pulse i_start again during WAIT with different i_data, and pulse i_tile_done during HOLD. Required: both ignored; o_tile_data unchanged; no extra tile write.
- Assert rst=0 mid-WAIT, release, then run a normal job. Required: o_busy=0 and o_data all 0 after reset; the following job completes correctly starting at addr 0.
- NUM_TILES=1 (OUTPUT_SIZE=256). Required: a single o_tile_start; o_start in cycle 4 with immediate done and i_busy=0.
